// File: rtl/bus_params_pkg.sv
// System bus widths shared by every bus-attached block.
package bus_params_pkg;
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
endpackage

// File: rtl/mem_resp_pkg.sv
// Response pipeline entry type and latency/outstanding limits for mem_resp_ctrl.
package mem_resp_pkg;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;
  // Wide enough to hold LAT_MAX outstanding transactions.
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic                              valid;
    logic                              err;
    logic [bus_params_pkg::BUS_DW-1:0] data;
  } resp_entry_t;
endpackage

// File: rtl/mem_resp_sram.sv
// Byte-enabled backing array: one write port with byte enables, one registered read port.
module mem_resp_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are never reset; only the requester defines them.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (wr_en && be[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (rd_en) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory responder: combinational grant with outstanding limit, fixed-latency
// in-order responses through a shift-register pipeline of response entries.
module mem_resp_ctrl
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH      = bus_params_pkg::BUS_AW,
  parameter int DATA_WIDTH      = bus_params_pkg::BUS_DW,
  parameter int MEM_WORDS       = 1024,
  parameter int RESP_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    request,
  output logic                    grant,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    stall,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err
);
  localparam int OFF_W  = $clog2(DATA_WIDTH/8);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [IDX_W:0] MEM_LIM = (IDX_W+1)'(MEM_WORDS);

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              unused_addr_lsb;
  logic [CNT_W-1:0]  out_q, out_d;
  logic              rd_sel_q, rd_sel_d;
  logic [DATA_WIDTH-1:0] sram_rdata;
  resp_entry_t       pipe_q [RESP_LATENCY];
  resp_entry_t       pipe_d [RESP_LATENCY];
  resp_entry_t       eff    [RESP_LATENCY];
  resp_entry_t       tail;

  assign idx             = addr[ADDR_WIDTH-1:OFF_W];
  assign unused_addr_lsb = ^addr[OFF_W-1:0];
  assign in_range        = ({1'b0, idx} < MEM_LIM);

  // A slot released by this cycle's response is immediately reusable.
  assign grant = request && !stall && !reset &&
                 ((out_q - CNT_W'(rvalid)) < CNT_W'(MAX_OUTSTANDING));

  mem_resp_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDX_W      (MEM_AW)
  ) u_sram (
    .clk   (clk),
    .wr_en (grant && we && in_range),
    .waddr (idx[MEM_AW-1:0]),
    .be    (be),
    .wdata (wdata),
    .rd_en (grant && !we && in_range),
    .raddr (idx[MEM_AW-1:0]),
    .rdata (sram_rdata)
  );

  // Stage 0 holds control only; read data arrives from the SRAM register one cycle later.
  always_comb begin
    for (int i = 0; i < RESP_LATENCY; i++) eff[i] = pipe_q[i];
    eff[0].data = rd_sel_q ? sram_rdata : '0;

    pipe_d[0].valid = grant;
    pipe_d[0].err   = grant && !in_range;
    pipe_d[0].data  = '0;
    for (int i = 1; i < RESP_LATENCY; i++) pipe_d[i] = eff[i-1];

    rd_sel_d = grant && !we && in_range;
    out_d    = out_q + CNT_W'(grant) - CNT_W'(rvalid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RESP_LATENCY; i++) pipe_q[i] <= '0;
      rd_sel_q <= 1'b0;
      out_q    <= '0;
    end else begin
      for (int i = 0; i < RESP_LATENCY; i++) pipe_q[i] <= pipe_d[i];
      rd_sel_q <= rd_sel_d;
      out_q    <= out_d;
    end
  end

  assign tail   = eff[RESP_LATENCY-1];
  assign rvalid = tail.valid && !reset;
  assign rdata  = rvalid ? tail.data : '0;
  assign err    = rvalid && tail.err;
endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed table-driven bench for mem_resp_ctrl plus reset and outstanding-limit sequences.
module tb_mem_resp_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        request, we, stall;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        grant, rvalid, err;
  logic [31:0] rdata;

  logic        req1, we1;
  logic [31:0] addr1, wdata1;
  logic        grant1, rvalid1, err1;
  logic [31:0] rdata1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_resp_ctrl dut (
    .clk(clk), .reset(reset), .request(request), .grant(grant), .addr(addr),
    .we(we), .be(be), .wdata(wdata), .stall(stall), .rvalid(rvalid),
    .rdata(rdata), .err(err)
  );

  mem_resp_ctrl #(.RESP_LATENCY(2), .MAX_OUTSTANDING(1)) dut1 (
    .clk(clk), .reset(reset), .request(req1), .grant(grant1), .addr(addr1),
    .we(we1), .be(4'hF), .wdata(wdata1), .stall(1'b0), .rvalid(rvalid1),
    .rdata(rdata1), .err(err1)
  );

  typedef struct {
    logic        req, stl, wr;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] wd;
    logic        g, rv, e;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic req, input logic stl, input logic wr,
                              input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd,
                              input logic g, input logic rv, input logic e, input logic [31:0] rd);
    vec_t v;
    v.req = req; v.stl = stl; v.wr = wr; v.a = a; v.b = b; v.wd = wd;
    v.g = g; v.rv = rv; v.e = e; v.rd = rd;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic stl, input logic wr,
                       input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd);
    request = req; stall = stl; we = wr; addr = a; be = b; wdata = wd;
  endtask

  task automatic check_out(input string tag, input logic g, input logic rv,
                           input logic e, input logic [31:0] rd);
    check({tag, " grant"},  32'(grant),  32'(g));
    check({tag, " rvalid"}, 32'(rvalid), 32'(rv));
    check({tag, " err"},    32'(err),    32'(e));
    check({tag, " rdata"},  rdata,       rd);
  endtask

  logic exp_g1 [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic exp_r1 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h0;

    // columns: req stall we addr be wdata | grant rvalid err rdata
    add(1,0,1,32'h10,  4'hF,32'hDEADBEEF, 1,0,0,32'h0);
    add(1,0,0,32'h10,  4'h0,32'h0,        1,0,0,32'h0);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,1,0,32'h0);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,1,0,32'hDEADBEEF);
    add(1,0,1,32'h20,  4'hF,32'h11223344, 1,0,0,32'h0);
    add(1,0,1,32'h20,  4'h2,32'h0000AA00, 1,0,0,32'h0);
    add(1,0,0,32'h20,  4'h0,32'h0,        1,1,0,32'h0);
    add(1,0,0,32'h1000,4'h0,32'h0,        1,1,0,32'h0);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,1,0,32'h1122AA44);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,1,1,32'h0);
    add(1,0,1,32'h0,   4'hF,32'h55AA55AA, 1,0,0,32'h0);
    add(1,0,1,32'h1000,4'hF,32'hFFFFFFFF, 1,0,0,32'h0);
    add(1,0,0,32'h0,   4'h0,32'h0,        1,1,0,32'h0);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,1,1,32'h0);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,1,0,32'h55AA55AA);
    add(1,0,0,32'h13,  4'h0,32'h0,        1,0,0,32'h0);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,0,0,32'h0);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,1,0,32'hDEADBEEF);
    add(1,1,1,32'h10,  4'hF,32'h0,        0,0,0,32'h0);
    add(1,1,1,32'h10,  4'hF,32'h0,        0,0,0,32'h0);
    add(1,1,1,32'h10,  4'hF,32'h0,        0,0,0,32'h0);
    add(1,0,0,32'h10,  4'h0,32'h0,        1,0,0,32'h0);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,0,0,32'h0);
    add(0,0,0,32'h0,   4'h0,32'h0,        0,1,0,32'hDEADBEEF);

    // Reset state with request asserted.
    @(negedge clk); #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    check("reset grant1", 32'(grant1), 32'h0);
    @(negedge clk); #1;
    check("reset rvalid1", 32'(rvalid1), 32'h0);
    req1 = 1'b0;

    @(negedge clk);
    reset = 1'b0;
    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].req, tbl[i].stl, tbl[i].wr, tbl[i].a, tbl[i].b, tbl[i].wd);
      #1;
      check_out($sformatf("row%0d", i), tbl[i].g, tbl[i].rv, tbl[i].e, tbl[i].rd);
    end

    // Reset while two reads are in flight.
    @(negedge clk); drive(1,0,0,32'h20,4'h0,32'h0); #1;
    check_out("rst_a", 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk); drive(1,0,0,32'h10,4'h0,32'h0); #1;
    check_out("rst_b", 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk); reset = 1'b1; drive(1,0,0,32'h10,4'h0,32'h0); #1;
    check_out("rst_c", 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); reset = 1'b0; drive(0,0,0,32'h0,4'h0,32'h0); #1;
    check_out("rst_d", 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_d outstanding", 32'(dut.out_q), 32'h0);
    @(negedge clk); drive(1,0,0,32'h20,4'h0,32'h0); #1;
    check_out("rst_e", 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk); drive(0,0,0,32'h0,4'h0,32'h0); #1;
    check_out("rst_f", 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    check_out("rst_g", 1'b0, 1'b1, 1'b0, 32'h1122AA44);

    // Single outstanding slot, latency 2: request held for four cycles.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req1 = (c < 4);
      #1;
      check($sformatf("lim%0d grant", c),  32'(grant1),  32'(exp_g1[c]));
      check($sformatf("lim%0d rvalid", c), 32'(rvalid1), 32'(exp_r1[c]));
      check($sformatf("lim%0d rdata", c),  rdata1,       32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
